// File: rtl/buffer_port_arbiter.sv
// ----------------------------------------------------------------------------
// buffer_port_arbiter
//
// Shares one single-port buffer SRAM between NUM_REQ requesters (typically the
// producers that feed the systolic-array FIFOs). Arbitration is round-robin:
// the last owner becomes lowest priority for the next round. A grant is held
// for as long as its owner keeps request high. The owner's SRAM controls are
// muxed onto the memory port; read data is broadcast to all requesters.
//
// Ports
//   clk, rstn        clock (posedge) / asynchronous active-low reset
//   req_mask         1 = requester takes part in arbitration
//   request          per-requester access request
//   grant            registered one-hot (or zero) grant
//   owner_id         index of the current / most recent owner
//   busy             arbiter not idle
//   hold_timeout     sticky flag: one grant held longer than MAX_HOLD cycles
//   clear_err        clears hold_timeout (a same-cycle set wins)
//   req_cs/oe/W_req  per-requester SRAM controls
//   req_addr         packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_W_data       packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_R_data       broadcast copy of mem_R_data
//   mem_*            the shared SRAM port
// ----------------------------------------------------------------------------
module buffer_port_arbiter #(
    parameter int   NUM_REQ    = 4,
    parameter int   DATA_WIDTH = 16,
    parameter int   ADDR_WIDTH = 20,
    parameter int   MAX_HOLD   = 1024,
    // Disabled-level encodings of the SRAM controls (single_port_ram_pkg
    // CS_DIS / OE_DIS / WREQ_DIS); override if the RAM uses other levels.
    parameter logic CS_DIS     = 1'b0,
    parameter logic OE_DIS     = 1'b0,
    parameter logic WREQ_DIS   = 1'b0
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_mask,
    input  logic [NUM_REQ-1:0]               request,
    output logic [NUM_REQ-1:0]               grant,
    output logic [$clog2(NUM_REQ)-1:0]       owner_id,
    output logic                             busy,
    output logic                             hold_timeout,
    input  logic                             clear_err,
    input  logic [NUM_REQ-1:0]               req_cs,
    input  logic [NUM_REQ-1:0]               req_oe,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_W_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_W_data,
    output logic [DATA_WIDTH-1:0]            req_R_data,
    output logic                             mem_cs,
    output logic                             mem_oe,
    output logic                             mem_W_req,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_W_data,
    input  logic [DATA_WIDTH-1:0]            mem_R_data
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int HCW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDW-1:0]     owner_nxt;
    logic [IDW-1:0]     rr_ptr, rr_nxt;
    logic [HCW-1:0]     hold_cnt, hold_nxt;
    logic               timeout_nxt;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     scan_idx;

    assign eligible = request & req_mask;

    // Round-robin search: scan rr_ptr+1, rr_ptr+2, ... so the previous owner
    // (held in rr_ptr) is looked at last.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Next-state, grant, pointer and watchdog logic
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        owner_nxt   = owner_id;
        rr_nxt      = rr_ptr;
        hold_nxt    = '0;
        timeout_nxt = hold_timeout & ~clear_err;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = NUM_REQ'(1) << winner;
                    owner_nxt = winner;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Watchdog only: flag the long hold but never revoke the grant.
                if (hold_cnt == HCW'(MAX_HOLD)) begin
                    timeout_nxt = 1'b1;
                end
                if (request[owner_id]) begin
                    hold_nxt = (hold_cnt == HCW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
                end else begin
                    grant_nxt = '0;
                    rr_nxt    = owner_id;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            grant        <= '0;
            owner_id     <= '0;
            rr_ptr       <= IDW'(NUM_REQ - 1);
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            owner_id     <= owner_nxt;
            rr_ptr       <= rr_nxt;
            hold_cnt     <= hold_nxt;
            hold_timeout <= timeout_nxt;
        end
    end

    assign busy = (state != IDLE);

    // The owner keeps the port through RELEASE so a producer can finish its
    // tail access after dropping request. Because state resets asynchronously,
    // the port is disabled the moment rstn falls.
    always_comb begin
        mem_cs     = CS_DIS;
        mem_oe     = OE_DIS;
        mem_W_req  = WREQ_DIS;
        mem_addr   = '0;
        mem_W_data = '0;
        if (state != IDLE) begin
            mem_cs     = req_cs[owner_id];
            mem_oe     = req_oe[owner_id];
            mem_W_req  = req_W_req[owner_id];
            mem_addr   = req_addr[owner_id*ADDR_WIDTH +: ADDR_WIDTH];
            mem_W_data = req_W_data[owner_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign req_R_data = mem_R_data;

endmodule

// File: tb/tb_buffer_port_arbiter.sv
module tb_buffer_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int MH = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_mask, request, grant;
    logic [1:0]        owner_id;
    logic              busy, hold_timeout, clear_err;
    logic [NR-1:0]     req_cs, req_oe, req_W_req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_W_data;
    logic [DW-1:0]     req_R_data, mem_W_data, mem_R_data;
    logic              mem_cs, mem_oe, mem_W_req;
    logic [AW-1:0]     mem_addr;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, whether the port is in its
    // post-release guard cycle, who owned it last, and how long it is held.
    bit m_owned, m_cool, m_to;
    int m_owner, m_last, m_held;

    buffer_port_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .rstn(rstn), .req_mask(req_mask), .request(request),
        .grant(grant), .owner_id(owner_id), .busy(busy),
        .hold_timeout(hold_timeout), .clear_err(clear_err),
        .req_cs(req_cs), .req_oe(req_oe), .req_addr(req_addr),
        .req_W_req(req_W_req), .req_W_data(req_W_data),
        .req_R_data(req_R_data), .mem_cs(mem_cs), .mem_oe(mem_oe),
        .mem_W_req(mem_W_req), .mem_addr(mem_addr),
        .mem_W_data(mem_W_data), .mem_R_data(mem_R_data)
    );

    always #5 clk = ~clk;

    wire [7:0]  dut_status = {grant, owner_id, busy, hold_timeout};
    wire [38:0] dut_port   = {mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data};

    function automatic int pick(input logic [NR-1:0] e, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owned = 0; m_cool = 0; m_to = 0;
        m_owner = 0; m_last = NR - 1; m_held = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        bit set_to;
        int w;
        // The grant cycle now ending is number m_held+1; beyond MAX_HOLD it flags.
        set_to = m_owned && (m_held + 1 > MH);
        if (m_owned) begin
            if (request[m_owner]) m_held++;
            else begin
                m_owned = 0; m_cool = 1; m_last = m_owner; m_held = 0;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else begin
            w = pick(request & req_mask, m_last);
            if (w >= 0) begin
                m_owned = 1; m_owner = w; m_held = 0;
            end
        end
        m_to = set_to || (m_to && !clear_err);
    endtask

    function automatic logic [7:0] exp_status();
        logic [NR-1:0] g;
        g = m_owned ? NR'(1 << m_owner) : '0;
        return {g, 2'(m_owner), m_owned | m_cool, m_to};
    endfunction

    function automatic logic [38:0] exp_port();
        if (m_owned || m_cool)
            return {req_cs[m_owner], req_oe[m_owner], req_W_req[m_owner],
                    req_addr[m_owner*AW +: AW], req_W_data[m_owner*DW +: DW]};
        return '0;
    endfunction

    task automatic cycle();
        if (rstn) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_mask = '1; request = '0; clear_err = 1'b0;
        req_cs = '1; req_oe = '1; req_W_req = '1;
        req_addr = '1; req_W_data = '1; mem_R_data = 16'h1234;
        model_reset();
        #3;
        checks++;
        if (dut_status !== 8'b0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", dut_status, 8'b0);
        end
        checks++;
        if (dut_port !== 39'b0) begin
            errors++; $display("FAIL reset_port: got %h expected %h", dut_port, 39'b0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        request = '0; req_cs = '0; req_oe = '0; req_W_req = '0;
        cycle();
        checks++;
        if (dut_status !== exp_status()) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", dut_status, exp_status());
        end
    endtask

    task automatic test_single();
        request = 4'b0001; req_cs = 4'b0001; req_addr = 80'({$urandom, $urandom, $urandom});
        cycle();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL single_grant_rise: got %b expected %b", grant, 4'b0001);
        end
        for (int k = 0; k < 5; k++) begin
            req_addr = 80'({$urandom, $urandom, $urandom});
            #1;
            checks++;
            if (mem_addr !== req_addr[AW-1:0] || dut_port !== exp_port()) begin
                errors++; $display("FAIL single_mux: got %h expected %h", dut_port, exp_port());
            end
            cycle();
            checks++;
            if (dut_status !== exp_status()) begin
                errors++; $display("FAIL single_hold: got %h expected %h", dut_status, exp_status());
            end
        end
        request = 4'b0000;
        cycle();
        checks++;
        if (grant !== 4'b0 || busy !== 1'b1 || owner_id !== 2'd0) begin
            errors++; $display("FAIL single_release: got g=%b busy=%b id=%0d expected g=0 busy=1 id=0",
                               grant, busy, owner_id);
        end
        req_addr = 80'({$urandom, $urandom, $urandom});
        #1;
        checks++;
        if (mem_addr !== req_addr[AW-1:0] || mem_cs !== 1'b1) begin
            errors++; $display("FAIL single_release_mux: got cs=%b addr=%h expected cs=1 addr=%h",
                               mem_cs, mem_addr, req_addr[AW-1:0]);
        end
        cycle();
        checks++;
        if (mem_cs !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle_port: got cs=%b busy=%b expected cs=0 busy=0", mem_cs, busy);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int zeros;
        int budget;
        do_reset();
        req_mask = '1; request = 4'b1111; req_cs = '0;
        zeros = 0;
        for (int n = 0; n < 5; n++) begin
            budget = 0;
            while (grant === 4'b0 && budget < 10) begin
                cycle();
                budget++;
                if (grant === 4'b0) zeros++;
            end
            checks++;
            if (grant !== 4'(1 << order[n])) begin
                errors++; $display("FAIL rr_order[%0d]: got %b expected %b", n, grant, 4'(1 << order[n]));
            end
            if (n > 0) begin
                checks++;
                if (zeros !== 2) begin
                    errors++; $display("FAIL rr_gap[%0d]: got %0d expected 2", n, zeros);
                end
            end
            repeat (3) begin
                cycle();
                checks++;
                if (dut_status !== exp_status()) begin
                    errors++; $display("FAIL rr_hold[%0d]: got %h expected %h", n, dut_status, exp_status());
                end
            end
            request[order[n]] = 1'b0;
            cycle();
            request = 4'b1111;
            zeros = 1;
            checks++;
            if (grant !== 4'b0) begin
                errors++; $display("FAIL rr_drop[%0d]: got %b expected 0000", n, grant);
            end
        end
    endtask

    task automatic test_mask();
        request = '0; req_cs = '0;
        repeat (2) cycle();
        req_mask = 4'b1101; request = 4'b0010; req_cs = 4'b0010;
        repeat (3) begin
            cycle();
            checks++;
            if (grant !== 4'b0 || busy !== 1'b0 || mem_cs !== 1'b0) begin
                errors++; $display("FAIL mask_block: got g=%b busy=%b cs=%b expected all zero",
                                   grant, busy, mem_cs);
            end
        end
        req_mask = '1; request = '0; req_cs = '0;
        repeat (2) cycle();
    endtask

    task automatic test_timeout();
        clear_err = 1'b0; request = 4'b0100;
        cycle();
        // Flag appears once the 9th grant cycle has completed.
        for (int j = 1; j <= 12; j++) begin
            checks++;
            if (grant !== 4'b0100 || hold_timeout !== (j >= MH + 2) || dut_status !== exp_status()) begin
                errors++; $display("FAIL timeout_cycle[%0d]: got g=%b to=%b expected g=0100 to=%b",
                                   j, grant, hold_timeout, (j >= MH + 2));
            end
            if (j < 12) cycle();
        end
        clear_err = 1'b1;
        cycle();
        checks++;
        if (hold_timeout !== 1'b1 || grant !== 4'b0100) begin
            errors++; $display("FAIL timeout_set_wins: got to=%b g=%b expected to=1 g=0100", hold_timeout, grant);
        end
        clear_err = 1'b0; request = '0;
        cycle();
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        checks++;
        if (hold_timeout !== 1'b0 || dut_status !== exp_status()) begin
            errors++; $display("FAIL timeout_clear: got %h expected %h", dut_status, exp_status());
        end
    endtask

    task automatic test_reset_mid_grant();
        request = '0; req_cs = '0;
        repeat (2) cycle();
        request = 4'b0010; req_cs = 4'b0010; req_addr = 80'({$urandom, $urandom, $urandom});
        cycle();
        cycle();
        checks++;
        if (grant !== 4'b0010 || mem_cs !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got g=%b cs=%b expected g=0010 cs=1", grant, mem_cs);
        end
        rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || mem_cs !== 1'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL midrst_drop: got g=%b busy=%b cs=%b addr=%h expected all zero",
                               grant, busy, mem_cs, mem_addr);
        end
        @(negedge clk);
        rstn = 1'b1; request = 4'b0011; req_cs = '0;
        cycle();
        checks++;
        if (grant !== 4'b0001 || dut_status !== exp_status()) begin
            errors++; $display("FAIL midrst_rr_ptr: got %b expected 0001", grant);
        end
    endtask

    task automatic test_random();
        request = '0;
        for (int n = 0; n < 400; n++) begin
            request   = request ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            req_mask  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            clear_err = ($urandom_range(0, 7) == 0);
            req_cs    = 4'($urandom); req_oe = 4'($urandom); req_W_req = 4'($urandom);
            req_addr  = 80'({$urandom, $urandom, $urandom});
            req_W_data = {$urandom, $urandom};
            mem_R_data = 16'($urandom);
            #1;
            checks++;
            if (dut_port !== exp_port() || req_R_data !== mem_R_data) begin
                errors++; $display("FAIL rand_port[%0d]: got %h/%h expected %h/%h",
                                   n, dut_port, req_R_data, exp_port(), mem_R_data);
            end
            cycle();
            checks++;
            if (dut_status !== exp_status()) begin
                errors++; $display("FAIL rand_status[%0d]: got %h expected %h", n, dut_status, exp_status());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
